ecc_secded_pipe: RTL and testbench
==================================

// Module: ecc_secded_pipe
// PURPOSE
//  Parametrised, pipelined Hamming SECDED codec. Encodes raw data into a codeword, or decodes
//  a codeword: corrects single-bit errors and flags double-bit errors.
//  Adds valid/ready flow control, per-beat encode/decode mode and saturating error counters.
//  Sits between the memory/link interface and consumers of protected data.
// PARAMETERS
//  DATA_W  26  payload bits per beat (>=4)
//  PAR_W   derived localparam: smallest r with 2**r >= DATA_W+r+1; 5 for the default
//  CODE_W  derived localparam: DATA_W+PAR_W+1; 32 for the default
//  CNT_W   16  width of each error counter
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       synchronous, active-high reset
//  in_valid    in   1       input beat present
//  in_ready    out  1       block accepts the input beat this cycle
//  in_mode     in   1       0 = encode, 1 = decode
//  in_code     in   CODE_W  decode: received codeword; encode: data in [DATA_W-1:0], upper bits ignored
//  out_valid   out  1       output beat present
//  out_ready   in   1       consumer accepts the output beat
//  out_mode    out  1       in_mode of the beat being output
//  out_code    out  CODE_W  encoded codeword, or corrected codeword (raw codeword on a 2-bit error)
//  out_data    out  DATA_W  payload extracted from out_code
//  err_1_bit   out  1       decode: single error corrected (always 0 in encode)
//  err_2_bit   out  1       decode: uncorrectable error (always 0 in encode)
//  cnt_clr     in   1       synchronously clear both counters
//  cnt_single  out  CNT_W   count of accepted beats with err_1_bit, saturating
//  cnt_double  out  CNT_W   count of accepted beats with err_2_bit, saturating
// BEHAVIOUR
//  Codeword layout:
//   - Bit i is Hamming position i for i = 1..CODE_W-1.
//   - Parity bits sit at power-of-2 positions.
//   - Data bits fill the remaining positions in ascending order, data[0] at position 3.
//   - Bit 0 is overall parity: XOR of bits 1..CODE_W-1, so the total codeword parity is even.
//  Decode:
//   - s = XOR of the indices of all set bits in positions 1..CODE_W-1; p = XOR of all CODE_W bits.
//   - s==0, p==0: no error.
//   - s==0, p==1: flip bit 0; err_1_bit=1.
//   - s!=0, p==1, s<CODE_W: flip bit s; err_1_bit=1.
//   - s!=0, p==1, s>=CODE_W: err_2_bit=1, no correction.
//   - s!=0, p==0: err_2_bit=1; codeword passed through unmodified.
//  Pipeline:
//   - Two register stages. S1 registers the input plus s and p; S2 registers the corrected or encoded result.
//   - Latency is 2 cycles from input handshake to out_valid when there is no stall.
//   - Throughput is 1 beat per clock.
//  Handshake:
//   - s2_load = !s2_valid | out_ready.
//   - s1_load = !s1_valid | s2_load.
//   - in_ready = s1_load (combinational from out_ready).
//   - Output fields hold stable while out_valid & !out_ready.
//   - Beats are never dropped or duplicated. Mixed-mode beats stay in order.
//  Counters:
//   - Update on output handshake (out_valid & out_ready) only.
//   - Saturate at 2**CNT_W-1.
//   - cnt_clr takes priority over a same-cycle increment; the result is 0.
//  Reset:
//   - Both stage-valid flags clear, so out_valid=0 and in_ready=1 in the cycle after rst.
//   - out_code, out_data, out_mode, err_1_bit, err_2_bit, cnt_single, cnt_double all reset to 0.
//   - Beats in flight when rst is asserted are discarded.
// TESTING (DATA_W=26, CODE_W=32)
//  1. Encode 26'h0000001 -> out_code=32'h0000000F, out_data=1, no error flags, exactly 2 cycles later.
//  2. Decode 32'h00000007 (bit 3 flipped) -> out_code=32'h0000000F, out_data=1, err_1_bit=1,
//     cnt_single=1. Decode 32'h0000000E (bit 0 flipped) -> out_code=32'h0000000F, err_1_bit=1.
//  3. Decode 32'h00000027 (bits 3,5 flipped) -> out_code=32'h00000027, err_2_bit=1, err_1_bit=0,
//     cnt_double=1.
//  4. Stream 8 back-to-back beats, out_ready low for cycles 3..5 ->
//     - in_ready drops once both stages are full;
//     - output values stay stable while stalled;
//     - all 8 beats come out in order, none lost.
//  5. Build with CNT_W=2 and send 5 single-error beats -> cnt_single sticks at 3.
//     Assert cnt_clr in the same cycle as a further error handshake -> cnt_single=0.
//  6. Assert rst with 2 beats in flight -> out_valid=0 next cycle, all outputs 0, no stale beat emerges.

Source files
------------

// File: rtl/ecc_secded_pipe.sv
// ecc_secded_pipe: two-stage pipelined Hamming SECDED encoder/decoder.
//
// Each beat carries its own mode: encode builds a codeword from the payload
// in in_code[DATA_W-1:0]; decode corrects a single-bit error or flags a
// double-bit error in a received codeword. Valid/ready flow control on both
// sides, and two saturating counters track error beats at the output.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input handshake
//   in_mode                  0 = encode, 1 = decode
//   in_code [CODE_W]         codeword (decode) or payload in low bits (encode)
//   out_valid/out_ready      output handshake
//   out_mode                 mode of the beat being presented
//   out_code [CODE_W]        encoded / corrected / raw (2-bit error) codeword
//   out_data [DATA_W]        payload extracted from out_code
//   err_1_bit, err_2_bit     decode status of the presented beat
//   cnt_clr                  clear both counters
//   cnt_single, cnt_double   saturating counts of error beats handed off
//
// Codeword layout: bit i (i>=1) is Hamming position i, parity at powers of
// two, data packed ascending into the rest (data[0] at position 3), bit 0 is
// overall even parity.
module ecc_secded_pipe #(
    parameter int  DATA_W = 26,
    parameter int  CNT_W  = 16,
    // Smallest r with 2**r >= DATA_W+r+1, reached by fixed-point iteration.
    localparam int PAR_W0 = $clog2(DATA_W + 1),
    localparam int PAR_W1 = $clog2(DATA_W + 1 + PAR_W0),
    localparam int PAR_W  = $clog2(DATA_W + 1 + PAR_W1),
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mode,
    output logic [CODE_W-1:0] out_code,
    output logic [DATA_W-1:0] out_data,
    output logic              err_1_bit,
    output logic              err_2_bit,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_single,
    output logic [CNT_W-1:0]  cnt_double
);

    localparam int CI_W = $clog2(CODE_W);
    localparam int DI_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Data bit k lives at the position i where i minus the number of powers
    // of two <= i, minus one, equals k.
    function automatic logic [CODE_W-1:0] place_data(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] w;
        w = '0;
        for (int i = 3; i < CODE_W; i++)
            if ((i & (i - 1)) != 0) w[CI_W'(i)] = d[DI_W'(i - $clog2(i + 1) - 1)];
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] w);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 3; i < CODE_W; i++)
            if ((i & (i - 1)) != 0) d[DI_W'(i - $clog2(i + 1) - 1)] = w[CI_W'(i)];
        return d;
    endfunction

    function automatic logic [PAR_W-1:0] syndrome(input logic [CODE_W-1:0] w);
        logic [PAR_W-1:0] s;
        s = '0;
        for (int i = 1; i < CODE_W; i++)
            if (w[CI_W'(i)]) s = s ^ PAR_W'(i);
        return s;
    endfunction

    logic              s1_valid_q, s1_valid_d, s1_mode_q, s1_mode_d, s1_par_q, s1_par_d;
    logic [CODE_W-1:0] s1_word_q, s1_word_d;
    logic [PAR_W-1:0]  s1_syn_q, s1_syn_d;
    logic              s2_valid_q, s2_valid_d, out_mode_q, out_mode_d;
    logic              err1_q, err1_d, err2_q, err2_d;
    logic [CODE_W-1:0] out_code_q, out_code_d;
    logic [CNT_W-1:0]  cnt_single_q, cnt_single_d, cnt_double_q, cnt_double_d;

    logic              s1_load, s2_load, out_fire;
    logic [CODE_W-1:0] front_word, res_code;
    logic              res_e1, res_e2;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;
    assign out_fire = s2_valid_q && out_ready;

    // In encode mode the word has zero parity slots, so its syndrome is
    // exactly the set of parity bits stage 2 has to insert.
    assign front_word = in_mode ? in_code : place_data(in_code[DATA_W-1:0]);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_word_d  = s1_word_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_mode_d = in_mode;
                s1_word_d = front_word;
                s1_syn_d  = syndrome(front_word);
                s1_par_d  = ^front_word;
            end
        end
    end

    always_comb begin
        res_code = s1_word_q;
        res_e1   = 1'b0;
        res_e2   = 1'b0;
        if (!s1_mode_q) begin
            // Parity slot 2**k takes syndrome bit k.
            for (int i = 1; i < CODE_W; i++)
                if ((i & (i - 1)) == 0) res_code[CI_W'(i)] = |(s1_syn_q & PAR_W'(i));
            res_code[0] = ^res_code[CODE_W-1:1];
        end else if (s1_syn_q == '0) begin
            if (s1_par_q) begin
                res_code[0] = ~res_code[0];
                res_e1      = 1'b1;
            end
        end else if (s1_par_q && (int'(s1_syn_q) < CODE_W)) begin
            res_code = s1_word_q ^ (CODE_W'(1) << s1_syn_q);
            res_e1   = 1'b1;
        end else begin
            // Even overall parity with a nonzero syndrome, or a syndrome
            // pointing past the codeword: uncorrectable, pass through raw.
            res_e2 = 1'b1;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        out_mode_d = out_mode_q;
        out_code_d = out_code_q;
        err1_d     = err1_q;
        err2_d     = err2_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_mode_d = s1_mode_q;
                out_code_d = res_code;
                err1_d     = res_e1;
                err2_d     = res_e2;
            end
        end
    end

    always_comb begin
        cnt_single_d = cnt_single_q;
        cnt_double_d = cnt_double_q;
        if (cnt_clr) begin
            cnt_single_d = '0;
            cnt_double_d = '0;
        end else if (out_fire) begin
            if (err1_q && cnt_single_q != CNT_MAX) cnt_single_d = cnt_single_q + CNT_W'(1);
            if (err2_q && cnt_double_q != CNT_MAX) cnt_double_d = cnt_double_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_mode_q    <= 1'b0;
            s1_word_q    <= '0;
            s1_syn_q     <= '0;
            s1_par_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            out_mode_q   <= 1'b0;
            out_code_q   <= '0;
            err1_q       <= 1'b0;
            err2_q       <= 1'b0;
            cnt_single_q <= '0;
            cnt_double_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_mode_q    <= s1_mode_d;
            s1_word_q    <= s1_word_d;
            s1_syn_q     <= s1_syn_d;
            s1_par_q     <= s1_par_d;
            s2_valid_q   <= s2_valid_d;
            out_mode_q   <= out_mode_d;
            out_code_q   <= out_code_d;
            err1_q       <= err1_d;
            err2_q       <= err2_d;
            cnt_single_q <= cnt_single_d;
            cnt_double_q <= cnt_double_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_mode   = out_mode_q;
    assign out_code   = out_code_q;
    assign out_data   = extract_data(out_code_q);
    assign err_1_bit  = err1_q;
    assign err_2_bit  = err2_q;
    assign cnt_single = cnt_single_q;
    assign cnt_double = cnt_double_q;

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Scoreboard bench for ecc_secded_pipe (DATA_W=26, CODE_W=32). A second
// instance with CNT_W=2 shares the same stimulus to exercise saturation.
module tb_ecc_secded_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_mode, out_ready, cnt_clr;
    logic [31:0] in_code;
    logic        in_ready, out_valid, out_mode, err_1_bit, err_2_bit;
    logic [31:0] out_code;
    logic [25:0] out_data;
    logic [15:0] cnt_single, cnt_double;
    logic        s_in_ready, s_out_valid, s_out_mode, s_err1, s_err2;
    logic [31:0] s_out_code;
    logic [25:0] s_out_data;
    logic [1:0]  s_cnt_single, s_cnt_double;

    always #5 clk = ~clk;

    ecc_secded_pipe #(.DATA_W(26), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_code(in_code), .out_valid(out_valid),
        .out_ready(out_ready), .out_mode(out_mode), .out_code(out_code),
        .out_data(out_data), .err_1_bit(err_1_bit), .err_2_bit(err_2_bit),
        .cnt_clr(cnt_clr), .cnt_single(cnt_single), .cnt_double(cnt_double));

    ecc_secded_pipe #(.DATA_W(26), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_mode(in_mode), .in_code(in_code), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_mode(s_out_mode), .out_code(s_out_code),
        .out_data(s_out_data), .err_1_bit(s_err1), .err_2_bit(s_err2),
        .cnt_clr(cnt_clr), .cnt_single(s_cnt_single), .cnt_double(s_cnt_double));

    typedef struct {
        logic        mode;
        logic [31:0] code;
        logic [25:0] data;
        logic        e1;
        logic        e2;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0, n_err = 0;
    int   m_single = 0, m_double = 0;
    logic rand_rdy = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Reference codec from the textual rules: data fills non-power-of-two
    // positions from 3 upward; parity 2**k covers positions with bit k set.
    function automatic logic [31:0] ref_enc(input logic [25:0] d);
        logic [31:0] c;
        int j;
        c = '0;
        j = 0;
        for (int p = 1; p < 32; p++)
            if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16) begin
                c[p] = d[j];
                j++;
            end
        for (int k = 0; k < 5; k++) begin
            logic par;
            par = 1'b0;
            for (int p = 1; p < 32; p++)
                if (((p >> k) & 1) == 1) par ^= c[p];
            c[1 << k] = par;
        end
        c[0] = ^c[31:1];
        return c;
    endfunction

    function automatic logic [25:0] ref_ext(input logic [31:0] c);
        logic [25:0] d;
        int j;
        d = '0;
        j = 0;
        for (int p = 1; p < 32; p++)
            if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16) begin
                d[j] = c[p];
                j++;
            end
        return d;
    endfunction

    // kind: 0 encode, 1 clean decode, 2 single error, 3 double error, else random
    task automatic gen(input int kind, output logic m, output logic [31:0] c, output exp_t e);
        logic [25:0] d;
        logic [31:0] cw;
        int k, a, b;
        k  = (kind >= 0 && kind <= 3) ? kind : int'($urandom_range(0, 3));
        d  = 26'($urandom);
        cw = ref_enc(d);
        a  = $urandom_range(0, 31);
        b  = (a + int'($urandom_range(1, 31))) % 32;
        e.e1 = 1'b0;
        e.e2 = 1'b0;
        m = (k != 0);
        case (k)
            0: begin c = {6'($urandom), d}; e.code = cw; end
            1: begin c = cw; e.code = cw; end
            2: begin c = cw ^ (32'd1 << a); e.code = cw; e.e1 = 1'b1; end
            default: begin c = cw ^ (32'd1 << a) ^ (32'd1 << b); e.code = c; e.e2 = 1'b1; end
        endcase
        e.mode = m;
        e.data = ref_ext(e.code);
    endtask

    // Presents one beat, holds it until accepted, returns just after the
    // accepting edge with in_valid still high (callers chain beats back-to-back).
    task automatic drive(input logic m, input logic [31:0] c, input exp_t e);
        logic ok;
        in_valid = 1'b1;
        in_mode  = m;
        in_code  = c;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) q.push_back(e);
        else chk("in_ready_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic mk_exp(input logic m, input logic [31:0] c, input logic e1, input logic e2,
                          output exp_t e);
        e.mode = m;
        e.code = c;
        e.data = ref_ext(c);
        e.e1   = e1;
        e.e2   = e2;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_left", 64'(q.size()), 64'(0));
    endtask

    // Monitor: pops the scoreboard on every output handshake, keeps the
    // counter model, and checks output stability across stalls.
    logic        stall_prev = 1'b0;
    logic [31:0] prev_code;
    logic        prev_mode, prev_e1, prev_e2;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_single   = 0;
            m_double   = 0;
            stall_prev = 1'b0;
        end else begin
            chk("cnt_single", 64'(cnt_single), 64'(m_single));
            chk("cnt_double", 64'(cnt_double), 64'(m_double));
            chk("sat_single", 64'(s_cnt_single), 64'(m_single > 3 ? 3 : m_single));
            chk("sat_double", 64'(s_cnt_double), 64'(m_double > 3 ? 3 : m_double));
            if (stall_prev) begin
                chk("stall_valid", 64'(out_valid), 64'(1));
                chk("stall_code", 64'(out_code), 64'(prev_code));
                chk("stall_flags", 64'({out_mode, err_1_bit, err_2_bit}),
                    64'({prev_mode, prev_e1, prev_e2}));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 64'(out_code), 64'(0));
                    if (out_code == 32'd0) begin
                        n_err++;
                        $display("FAIL unexpected_beat: got a beat, required none");
                    end
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_code", 64'(out_code), 64'(e.code));
                    chk("out_data", 64'(out_data), 64'(e.data));
                    chk("out_mode", 64'(out_mode), 64'(e.mode));
                    chk("err_flags", 64'({err_1_bit, err_2_bit}), 64'({e.e1, e.e2}));
                    if (e.e1 && m_single < 65535) m_single++;
                    if (e.e2 && m_double < 65535) m_double++;
                end
            end
            if (cnt_clr) begin
                m_single = 0;
                m_double = 0;
            end
            stall_prev = out_valid && !out_ready;
            prev_code  = out_code;
            prev_mode  = out_mode;
            prev_e1    = err_1_bit;
            prev_e2    = err_2_bit;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        logic        m;
        logic [31:0] c;
        exp_t        e;
        logic        saw_block;

        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_code = '0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_code", 64'(out_code), 64'(0));

        // Directed vectors with latency check on the first one.
        mk_exp(1'b0, 32'h0000000F, 1'b0, 1'b0, e);
        drive(1'b0, 32'h00000001, e);
        in_valid = 1'b0;
        chk("latency_c1", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1 chk("latency_c2", 64'(out_valid), 64'(1));
        mk_exp(1'b1, 32'h0000000F, 1'b1, 1'b0, e);
        drive(1'b1, 32'h00000007, e);
        drive(1'b1, 32'h0000000E, e);
        mk_exp(1'b1, 32'h00000027, 1'b0, 1'b1, e);
        drive(1'b1, 32'h00000027, e);
        in_valid = 1'b0;
        wait_drain();
        chk("dir_cnt_single", 64'(cnt_single), 64'(2));
        chk("dir_cnt_double", 64'(cnt_double), 64'(1));

        // Back-to-back stream with a three-cycle output stall.
        saw_block = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    gen(-1, m, c, e);
                    drive(m, c, e);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    @(negedge clk);
                    if (!in_ready) saw_block = 1'b1;
                end
            end
        join
        chk("in_ready_dropped", 64'(saw_block), 64'(1));
        wait_drain();

        // Random traffic with random backpressure, gaps and counter clears.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            gen(-1, m, c, e);
            cnt_clr = ($urandom_range(0, 60) == 0);
            drive(m, c, e);
            cnt_clr = 1'b0;
        end
        in_valid = 1'b0;
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Saturation on the 2-bit counter, then clear vs same-cycle increment.
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            gen(2, m, c, e);
            drive(m, c, e);
        end
        in_valid = 1'b0;
        wait_drain();
        chk("sat_stick_3", 64'(s_cnt_single), 64'(3));
        chk("wide_cnt_5", 64'(cnt_single), 64'(5));
        out_ready = 1'b0;
        gen(2, m, c, e);
        drive(m, c, e);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        @(negedge clk);
        chk("clr_setup_valid", 64'(out_valid), 64'(1));
        cnt_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        chk("clr_prio_small", 64'(s_cnt_single), 64'(0));
        chk("clr_prio_wide", 64'(cnt_single), 64'(0));

        // Reset with two beats in flight.
        out_ready = 1'b0;
        mk_exp(1'b1, 32'h0000000F, 1'b1, 1'b0, e);
        drive(1'b1, 32'h00000007, e);
        mk_exp(1'b1, 32'h00000027, 1'b0, 1'b1, e);
        drive(1'b1, 32'h00000027, e);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("inflight_rst_valid", 64'(out_valid), 64'(0));
        chk("inflight_rst_ready", 64'(in_ready), 64'(1));
        chk("inflight_rst_outs", 64'({out_code, out_mode, err_1_bit, err_2_bit}), 64'(0));
        chk("inflight_rst_data", 64'(out_data), 64'(0));
        chk("inflight_rst_cnts", 64'({cnt_single, cnt_double}), 64'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale_beat", 64'(out_valid), 64'(0));
        end

        // One clean encode after reset to show the pipe still works.
        gen(0, m, c, e);
        drive(m, c, e);
        in_valid = 1'b0;
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
